// File: rtl/nes_multi_pad_reader.sv
// Polls NUM_PADS NES/SNES serial controllers over one shared latch/pulse pair and
// publishes per-frame button state with one-cycle pressed/released event masks.
module nes_multi_pad_reader #(
  parameter int NUM_PADS  = 2,
  parameter int NUM_BITS  = 8,
  parameter int CLK_DIV   = 300,
  parameter int POLL_GAP  = 200000,
  parameter int AUTO_POLL = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PADS-1:0]          data,
  input  logic                         start,
  output logic                         latch,
  output logic                         pulse,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic                         valid,
  output logic                         busy
);

  localparam int PW = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(NUM_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [PW-1:0] phase;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap;
  logic          phase_end;
  logic          latch_d, pulse_d, busy_d;

  logic [NUM_PADS-1:0][NUM_BITS-1:0] shadow;

  always_comb begin
    phase_end = 1'b0;
    case (state)
      S_LATCH:      phase_end = (phase == LATCH_LAST);
      S_LOW, S_HIGH: phase_end = (phase == HALF_LAST);
      default:      phase_end = 1'b0;
    endcase
  end

  // State register and the phase/bit/gap counters that pace it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      gap     <= '0;
    end else begin
      state <= next_state;
      if (next_state != state || state == S_IDLE) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
      if (state == S_IDLE && next_state == S_IDLE) begin
        gap <= gap + 1'b1;
      end else begin
        gap <= '0;
      end
      if (state == S_LATCH && phase_end) begin
        bit_cnt <= BW'(1);
      end else if (state == S_HIGH && phase_end && bit_cnt != LAST_BIT) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (AUTO_POLL != 0) begin
          if (gap == GAP_LAST) next_state = S_LATCH;
        end else if (start) begin
          next_state = S_LATCH;
        end
      end
      S_LATCH: if (phase_end) next_state = (NUM_BITS == 1) ? S_DONE : S_LOW;
      S_LOW:   if (phase_end) next_state = S_HIGH;
      S_HIGH:  if (phase_end) next_state = (bit_cnt == LAST_BIT) ? S_DONE : S_LOW;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered pins line up with state.
  always_comb begin
    latch_d = (next_state == S_LATCH);
    pulse_d = (next_state == S_HIGH);
    busy_d  = (next_state != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      latch <= 1'b0;
      pulse <= 1'b0;
      busy  <= 1'b0;
    end else begin
      latch <= latch_d;
      pulse <= pulse_d;
      busy  <= busy_d;
    end
  end

  // Shadow capture; every bit is rewritten each frame so a partial frame needs no clear.
  always_ff @(posedge clock) begin
    if (state == S_LATCH && phase_end) begin
      for (int p = 0; p < NUM_PADS; p++) shadow[p][0] <= ~data[p];
    end else if (state == S_HIGH && phase_end) begin
      for (int p = 0; p < NUM_PADS; p++) shadow[p][bit_cnt] <= ~data[p];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buttons  <= '0;
      pressed  <= '0;
      released <= '0;
      valid    <= 1'b0;
    end else if (state == S_DONE) begin
      buttons  <= shadow;
      pressed  <= shadow & ~buttons;
      released <= ~shadow & buttons;
      valid    <= 1'b1;
    end else begin
      pressed  <= '0;
      released <= '0;
      valid    <= 1'b0;
    end
  end

endmodule

// File: doc/nes_multi_pad_reader.md
# nes_multi_pad_reader

Parametrised successor to the single-pad NES-to-LED reader. It polls NUM_PADS NES/SNES-style serial controllers in parallel over one shared latch/pulse pair and captures NUM_BITS buttons per pad. It publishes the debounced-per-frame button state plus one-cycle pressed/released event masks and a frame-valid strobe. It sits between the controller port pins and game/display logic.

## Interface
- NUM_PADS, 2: number of controllers sharing latch/pulse; one data line each.
- NUM_BITS, 8: bits per frame (8 = NES, 16 = SNES).
- CLK_DIV, 300: length of each pulse half-period in clock cycles; must be ≥1.
- POLL_GAP, 200000: IDLE cycles between frames in auto mode; must be ≥1.
- AUTO_POLL, 1: 1 = free-running polling; 0 = a frame starts only on `start`.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- data  in  NUM_PADS  serial data from the pads, active-low (0 = button pressed).
- start  in  1  frame request; used only when AUTO_POLL=0.
- latch  out  1  controller latch, active-high.
- pulse  out  1  controller shift clock, active-high.
- buttons  out  NUM_PADS*NUM_BITS  held button state, active-high.
  - Pad p, bit k is at index p*NUM_BITS+k; bit 0 is the first bit shifted out (A on NES).
- pressed  out  NUM_PADS*NUM_BITS  one-cycle mask of 0→1 transitions.
- released  out  NUM_PADS*NUM_BITS  one-cycle mask of 1→0 transitions.
- valid  out  1  one-cycle strobe when buttons/pressed/released update.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, LATCH, LOW, HIGH and DONE.
- One phase counter (width clog2(2*CLK_DIV)) and one bit counter (width clog2(NUM_BITS)).
- IDLE: latch=0, pulse=0.
  - Auto mode: stay POLL_GAP cycles, then go to LATCH.
  - Manual mode: go to LATCH on the cycle after `start`=1 is sampled.
- LATCH: latch=1 for 2*CLK_DIV cycles. On the last cycle, sample bit 0 of every pad into the shadow register: shadow[p*NUM_BITS+0] = ~data[p].
  - If NUM_BITS=1, go to DONE; otherwise go to LOW with bit counter = 1.
- LOW: pulse=0 for CLK_DIV cycles, then go to HIGH.
- HIGH: pulse=1 for CLK_DIV cycles. On the last cycle, sample bit k = bit counter for all pads.
  - If k = NUM_BITS-1, go to DONE; otherwise increment k and go to LOW.
- DONE: exactly one cycle, latch=0, pulse=0. On the DONE→IDLE edge:
  - buttons ← shadow
  - pressed ← shadow & ~buttons_old
  - released ← ~shadow & buttons_old
  - valid ← 1
- pressed, released and valid are 0 in every other cycle.
- buttons holds its value between frames and never changes mid-frame.
- `start` is ignored outside IDLE and ignored entirely when AUTO_POLL=1; it is not queued.
- Reset, including mid-frame:
  - FSM returns to IDLE and both counters clear.
  - The partial shadow frame is discarded.
  - latch, pulse, buttons, pressed, released, valid and busy all read 0 on the cycle after reset is sampled high.
  - The IDLE gap restarts from 0 after reset deasserts.

## Timing
- Outputs latch, pulse, busy and valid are registered; there is no combinational path from data or start to any output.
- Frame length, LATCH entry to IDLE entry: 2*CLK_DIV + (NUM_BITS-1)*2*CLK_DIV + 1 cycles.
- Data must be stable on the sampling edge only, i.e. the last cycle of LATCH or HIGH; it is asynchronous to nothing else.
- Auto-mode period: POLL_GAP + frame length.
- Manual mode: `start` sampled at cycle t gives latch=1 from t+1.
- valid asserts on the cycle after DONE, concurrent with IDLE entry; the new buttons value is visible in that same cycle.

## Test plan
- **Reset values.** Params NUM_PADS=2, NUM_BITS=8, CLK_DIV=2, POLL_GAP=4, AUTO_POLL=1. Hold reset 3 cycles → all outputs 0; latch rises exactly 4 cycles after reset falls; latch is high 4 cycles; 7 pulse highs of 2 cycles each; frame length 33.
- **Per-pad capture.** Drive pad0 bits = 8'b0101_0101 active-low, pad1 all 1 → on valid, buttons = 16'h00AA; pressed = 16'h00AA; released = 0.
- **Events.** Next frame pad0 all 1, pad1 bit 3 = 0 → buttons = 16'h0800, pressed = 16'h0800, released = 16'h00AA, each for exactly one cycle.
- **Manual mode.** AUTO_POLL=0: no latch for 100 cycles; pulse `start` during a frame → ignored; pulse `start` in IDLE → latch=1 on the next cycle; exactly one valid per accepted start.
- **Reset mid-frame.** Assert reset during the 4th HIGH → latch/pulse drop to 0 the next cycle, buttons = 0, no valid; a full new frame follows the gap.
- **SNES width.** NUM_BITS=16, NUM_PADS=1, CLK_DIV=1 → 15 pulses, frame length 33; pattern 16'hA5C3 (active-high) captured bit-exact.
